// File: rtl/riscv_chk_pkg.sv
// Shared types for the RISC-V commit checker: FSM states, failure codes and table entries.
package riscv_chk_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        PASS_S = 2'd2,
        FAIL_S = 2'd3
    } state_t;

    localparam logic [2:0] FAIL_NONE       = 3'd0;
    localparam logic [2:0] FAIL_MISMATCH   = 3'd1;
    localparam logic [2:0] FAIL_SKIPPED    = 3'd2;
    localparam logic [2:0] FAIL_INCOMPLETE = 3'd3;
    localparam logic [2:0] FAIL_TIMEOUT    = 3'd4;

    typedef struct packed {
        logic [31:0] num_inst;
        logic [31:0] ans;
    } entry_t;

endpackage

// File: rtl/riscv_chk_history.sv
// 4-deep ring of {NUM_INST, OUTPUT_PORT} snapshots, pushed when NUM_INST changes while run is high.
module riscv_chk_history (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] num_inst,
    input  logic [31:0] output_port,
    input  logic [1:0]  rd_idx,
    output logic [63:0] rd_data
);

    logic [63:0] ring [4];
    logic [1:0]  wr_ptr;
    logic [2:0]  fill;
    logic [31:0] prev_num;
    logic [1:0]  rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ring[i] <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            prev_num <= '0;
        end else begin
            prev_num <= num_inst;
            if (run && (num_inst != prev_num)) begin
                ring[wr_ptr] <= {num_inst, output_port};
                wr_ptr       <= wr_ptr + 2'd1;
                if (fill != 3'd4) fill <= fill + 3'd1;
            end
        end
    end

    // Index 0 is the newest entry; slots never written read as zero.
    assign rd_ptr  = wr_ptr - 2'd1 - rd_idx;
    assign rd_data = ({1'b0, rd_idx} < fill) ? ring[rd_ptr] : '0;

endmodule

// File: rtl/riscv_commit_checker.sv
// Retired-instruction checkpoint checker for RISCV_TOP runs on FPGA.
// Optional history ring enabled by defining RISCV_CHK_HISTORY_EN.
module riscv_commit_checker
    import riscv_chk_pkg::*;
#(
    parameter int NUM_TEST = 22,
    parameter int IDX_W    = 5,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                LD_WE,
    input  logic [IDX_W-1:0]    LD_IDX,
    input  logic [31:0]         LD_NUM_INST,
    input  logic [31:0]         LD_ANS,
    input  logic [IDX_W:0]      LD_COUNT,
    input  logic                START,
    input  logic [31:0]         NUM_INST,
    input  logic [31:0]         OUTPUT_PORT,
    input  logic                HALT,
    output logic                DONE,
    output logic                PASS,
    output logic [2:0]          FAIL_CODE,
    output logic [IDX_W-1:0]    FAIL_IDX,
    output logic [31:0]         FAIL_VALUE,
    output logic [NUM_TEST-1:0] PASS_MASK,
    output logic [31:0]         CYCLE_CNT,
    input  logic [1:0]          HIST_RD_IDX,
    output logic [63:0]         HIST_DATA
);

    localparam int              CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_TEST);
    localparam logic [31:0]      TO_LIMIT = 32'(TIMEOUT - 1);

    state_t           state, state_nxt;
    entry_t           table_q [NUM_TEST];
    entry_t           cur;
    logic [CNT_W-1:0] ptr;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       code_nxt;
    logic             match;
    logic             timeout_hit;

    assign cur         = table_q[ptr[IDX_W-1:0]];
    assign timeout_hit = (TIMEOUT != 0) && (CYCLE_CNT >= TO_LIMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= LOAD;
        else     state <= state_nxt;
    end

    // One table entry is examined per RUN cycle; checkpoint events outrank HALT, which outranks timeout.
    always_comb begin
        state_nxt = state;
        code_nxt  = FAIL_NONE;
        match     = 1'b0;
        case (state)
            LOAD: if (START) state_nxt = RUN;
            RUN: begin
                if (ptr < count_q) begin
                    if (NUM_INST == cur.num_inst) begin
                        if (OUTPUT_PORT == cur.ans) begin
                            match = 1'b1;
                        end else begin
                            state_nxt = FAIL_S;
                            code_nxt  = FAIL_MISMATCH;
                        end
                    end else if (NUM_INST > cur.num_inst) begin
                        state_nxt = FAIL_S;
                        code_nxt  = FAIL_SKIPPED;
                    end else if (HALT) begin
                        state_nxt = FAIL_S;
                        code_nxt  = FAIL_INCOMPLETE;
                    end else if (timeout_hit) begin
                        state_nxt = FAIL_S;
                        code_nxt  = FAIL_TIMEOUT;
                    end
                end else if (HALT) begin
                    state_nxt = PASS_S;
                end else if (timeout_hit) begin
                    state_nxt = FAIL_S;
                    code_nxt  = FAIL_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        DONE = (state == PASS_S) || (state == FAIL_S);
        PASS = (state == PASS_S);
    end

    // Table storage has no reset; it is only trusted after a reload in LOAD.
    always_ff @(posedge CLK) begin
        if ((state == LOAD) && LD_WE && ({1'b0, LD_IDX} < MAX_CNT))
            table_q[LD_IDX] <= '{num_inst: LD_NUM_INST, ans: LD_ANS};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr        <= '0;
            count_q    <= '0;
            PASS_MASK  <= '0;
            CYCLE_CNT  <= '0;
            FAIL_CODE  <= FAIL_NONE;
            FAIL_IDX   <= '0;
            FAIL_VALUE <= '0;
        end else begin
            if ((state == LOAD) && START) begin
                count_q   <= (LD_COUNT > MAX_CNT) ? MAX_CNT : LD_COUNT;
                ptr       <= '0;
                PASS_MASK <= '0;
                CYCLE_CNT <= '0;
            end
            if (state == RUN) begin
                if (CYCLE_CNT != '1) CYCLE_CNT <= CYCLE_CNT + 32'd1;
                if (match) begin
                    PASS_MASK[ptr[IDX_W-1:0]] <= 1'b1;
                    ptr                       <= ptr + 1'b1;
                end
                if (state_nxt == FAIL_S) begin
                    FAIL_CODE  <= code_nxt;
                    FAIL_IDX   <= ptr[IDX_W-1:0];
                    FAIL_VALUE <= (code_nxt == FAIL_MISMATCH) ? OUTPUT_PORT : NUM_INST;
                end
            end
        end
    end

`ifdef RISCV_CHK_HISTORY_EN
    riscv_chk_history u_history (
        .clk         (CLK),
        .rst         (RST),
        .run         (state == RUN),
        .num_inst    (NUM_INST),
        .output_port (OUTPUT_PORT),
        .rd_idx      (HIST_RD_IDX),
        .rd_data     (HIST_DATA)
    );
`else
    logic unused_hist_rd;
    assign unused_hist_rd = ^HIST_RD_IDX;
    assign HIST_DATA      = '0;
`endif

endmodule
